// File: rtl/vbuf_fifo.sv
// Byte FIFO behind the video stream extender. It buffers stream bytes for the readout
// consumer, follows end-of-stream through the pad phase, and flags when the FIFO has drained.
module vbuf_fifo #(
   parameter int ADDR_W  = 6,
   parameter int PAD_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              stream_end,
   input  logic [7:0]        vbuf_in,
   input  logic              vbuf_wr_in,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              drained
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN, S_DONE} state_t;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_req, wr_acc, rd_acc;
   state_t            state, state_nxt;
   logic [7:0]        pad_cnt, pad_cnt_nxt;

   assign empty  = (level == '0);
   assign full   = (level == (ADDR_W+1)'(DEPTH));
   assign wr_req = clk_en & vbuf_wr_in;
   assign rd_acc = rd_en & ~empty;
   // A read frees a slot in the same cycle, so a full FIFO can still take a write.
   assign wr_acc = wr_req & (~full | rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= vbuf_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         if (wr_acc && !rd_acc)      level <= level + 1'b1;
         else if (rd_acc && !wr_acc) level <= level - 1'b1;
         if (wr_req && !wr_acc) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_RUN;
         pad_cnt <= '0;
         drained <= 1'b0;
      end else begin
         state   <= state_nxt;
         pad_cnt <= pad_cnt_nxt;
         drained <= (state_nxt == S_DONE);
      end
   end

   // Pad strobes are counted whether or not the FIFO had room for them.
   always_comb begin
      state_nxt   = state;
      pad_cnt_nxt = pad_cnt;
      unique case (state)
         S_RUN:   if (clk_en && stream_end) state_nxt = S_PAD;
         S_PAD: begin
            if (wr_req) begin
               pad_cnt_nxt = pad_cnt + 1'b1;
               if (pad_cnt == 8'(PAD_LEN-1)) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: if (empty && !wr_acc) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_RUN;
      endcase
   end

endmodule
